// File: rtl/mem_arb_pkg.sv
// Shared types and AXI3 constants for the instruction/data memory request arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AWW  = 3'd3,
    B    = 3'd4,
    DONE = 3'd5
  } state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } grant_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

endpackage

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one AXI3 master port between instruction fetch and
// load/store. One single-beat transaction outstanding at a time; all outputs registered.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  // Data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  // Status
  output logic        bus_err,
  output logic        busy,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_e r_state;
  grant_e r_last_grant;
  grant_e r_winner;
  logic   r_aw_pend;
  logic   r_w_pend;

  logic   w_any_req;
  logic   w_grant_data;
  logic   w_aw_pend_nxt;
  logic   w_w_pend_nxt;
  // Only one transaction is ever in flight, so response IDs carry no information.
  logic   w_unused_ids;

  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign wlast   = 1'b1;

  assign w_unused_ids  = ^{rid, bid};

  // Data wins when alone, or on a tie when instruction fetch had the previous grant.
  assign w_any_req     = inst_req | data_req;
  assign w_grant_data  = data_req & (~inst_req | (r_last_grant == INST));
  // Pending flags after this cycle's handshakes; AW and W retire independently.
  assign w_aw_pend_nxt = r_aw_pend & ~awready;
  assign w_w_pend_nxt  = r_w_pend & ~wready;

  // Transaction FSM with registered AXI and requester outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= INST;
      r_winner     <= INST;
      r_aw_pend    <= 1'b0;
      r_w_pend     <= 1'b0;
      inst_rdata   <= '0;
      inst_done    <= 1'b0;
      data_rdata   <= '0;
      data_done    <= 1'b0;
      bus_err      <= 1'b0;
      busy         <= 1'b0;
      arid         <= '0;
      araddr       <= '0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awid         <= '0;
      awaddr       <= '0;
      awvalid      <= 1'b0;
      wid          <= '0;
      wdata        <= '0;
      wstrb        <= '0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            busy <= 1'b1;
            if (w_grant_data) begin
              r_winner     <= DATA;
              r_last_grant <= DATA;
              if (data_wr) begin
                awid      <= ID_DATA;
                awaddr    <= {data_addr[31:2], 2'b00};
                wid       <= ID_DATA;
                wdata     <= data_wdata;
                wstrb     <= data_wstrb;
                awvalid   <= 1'b1;
                wvalid    <= 1'b1;
                r_aw_pend <= 1'b1;
                r_w_pend  <= 1'b1;
                r_state   <= AWW;
              end else begin
                arid    <= ID_DATA;
                araddr  <= {data_addr[31:2], 2'b00};
                arvalid <= 1'b1;
                r_state <= AR;
              end
            end else begin
              r_winner     <= INST;
              r_last_grant <= INST;
              arid         <= ID_INST;
              araddr       <= {inst_addr[31:2], 2'b00};
              arvalid      <= 1'b1;
              r_state      <= AR;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R;
          end
        end
        R: begin
          if (rvalid && rlast) begin
            rready  <= 1'b0;
            bus_err <= (rresp != 2'b00);
            if (r_winner == INST) begin
              inst_done  <= 1'b1;
              inst_rdata <= rdata;
            end else begin
              data_done  <= 1'b1;
              data_rdata <= rdata;
            end
            r_state <= DONE;
          end
        end
        AWW: begin
          r_aw_pend <= w_aw_pend_nxt;
          r_w_pend  <= w_w_pend_nxt;
          awvalid   <= w_aw_pend_nxt;
          wvalid    <= w_w_pend_nxt;
          if (!w_aw_pend_nxt && !w_w_pend_nxt) begin
            bready  <= 1'b1;
            r_state <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            bus_err    <= (bresp != 2'b00);
            data_done  <= 1'b1;
            data_rdata <= '0;
            r_state    <= DONE;
          end
        end
        DONE: begin
          inst_done  <= 1'b0;
          data_done  <= 1'b0;
          inst_rdata <= '0;
          data_rdata <= '0;
          bus_err    <= 1'b0;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; the bench itself plays the AXI slave.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_err;
  logic        busy;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_done  (inst_done),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_wstrb (data_wstrb),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_done  (data_done),
    .bus_err    (bus_err),
    .busy       (busy),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready),
    .awid       (awid),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .awvalid    (awvalid),
    .awready    (awready),
    .wid        (wid),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bid        (bid),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every valid/ready/done/status output and every payload output is zero.
  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, {23'd0, arvalid, rready, awvalid, wvalid, bready,
                        inst_done, data_done, bus_err, busy}, 32'd0);
    chk({tag, ".araddr"}, araddr, 32'd0);
    chk({tag, ".awaddr"}, awaddr, 32'd0);
    chk({tag, ".wdata"}, wdata, 32'd0);
    chk({tag, ".ids"}, {16'd0, arid, awid, wid, wstrb}, 32'd0);
    chk({tag, ".rdata"}, inst_rdata | data_rdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    chk("fixed", {16'd0, arlen, arsize, arburst, awlen, awsize, awburst, wlast},
        {16'd0, 4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 1'b1});
    rst_n = 1'b1;

    // Instruction read, slave ready immediately
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h2408_0001;
    tick();
    chk("rd1.arvalid", arvalid, 1);
    chk("rd1.araddr", araddr, 32'hBFC0_0004);
    chk("rd1.arid", arid, 0);
    chk("rd1.busy", busy, 1);
    tick();
    chk("rd1.ar_drop", {arvalid, rready}, 2'b01);
    tick();
    chk("rd1.done", {inst_done, data_done, bus_err}, 3'b100);
    chk("rd1.rdata", inst_rdata, 32'h2408_0001);
    inst_req = 1'b0;
    tick();
    chk("rd1.idle", {inst_done, busy, rready}, 3'b000);

    // Both requesting from reset: data first, then alternate
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0010;
    rdata = 32'hAAAA_0001;
    tick();
    chk("rr.g1.arid", arid, 1);
    chk("rr.g1.araddr", araddr, 32'h8000_0010);
    tick();
    tick();
    chk("rr.g1.done", {inst_done, data_done}, 2'b01);
    chk("rr.g1.rdata", data_rdata, 32'hAAAA_0001);
    rdata = 32'hAAAA_0002;
    tick();
    chk("rr.idle", {busy, arvalid, data_done}, 3'b000);
    tick();
    chk("rr.g2.arid", arid, 0);
    chk("rr.g2.araddr", araddr, 32'hBFC0_0000);
    tick();
    tick();
    chk("rr.g2.done", {inst_done, data_done}, 2'b10);
    chk("rr.g2.rdata", inst_rdata, 32'hAAAA_0002);
    tick();
    tick();
    chk("rr.g3.arid", arid, 1);
    chk("rr.g3.araddr", araddr, 32'h8000_0010);
    tick();
    tick();
    chk("rr.g3.done", {inst_done, data_done}, 2'b01);
    inst_req = 1'b0; data_req = 1'b0;
    tick();
    chk("rr.end", {busy, inst_done, data_done}, 3'b000);

    // Store with late AW acceptance
    arready = 1'b0; rvalid = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0003;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b1000;
    awready = 1'b0; wready = 1'b1;
    tick();
    chk("st.valids", {awvalid, wvalid, arvalid}, 3'b110);
    chk("st.awaddr", awaddr, 32'h8000_0000);
    chk("st.wdata", wdata, 32'hDEAD_BEEF);
    chk("st.ids", {awid, wid, wstrb}, {4'd1, 4'd1, 4'b1000});
    tick();
    chk("st.c2", {awvalid, wvalid}, 2'b10);
    chk("st.c2.awaddr", awaddr, 32'h8000_0000);
    tick();
    chk("st.c3", {awvalid, wvalid, bready}, 3'b100);
    awready = 1'b1;
    tick();
    chk("st.b", {awvalid, wvalid, bready, data_done}, 4'b0010);
    awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    tick();
    chk("st.done", {data_done, inst_done, bus_err, bready}, 4'b1000);
    chk("st.rdata", data_rdata, 32'd0);
    data_req = 1'b0; bvalid = 1'b0;
    tick();
    chk("st.idle", {busy, data_done}, 2'b00);

    // Read with slow AR and SLVERR response
    data_wr = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rresp = 2'b10; rdata = 32'h1234_5678;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("slow.arvalid%0d", i), arvalid, 1);
      chk($sformatf("slow.araddr%0d", i), araddr, 32'hBFC0_0008);
      if (i < 5) tick();
    end
    arready = 1'b1;
    tick();
    chk("slow.r", {arvalid, rready}, 2'b01);
    arready = 1'b0;
    tick();
    chk("slow.done", {inst_done, bus_err}, 2'b11);
    chk("slow.rdata", inst_rdata, 32'h1234_5678);
    inst_req = 1'b0; rresp = 2'b00;
    tick();
    chk("slow.idle", {inst_done, bus_err, busy}, 3'b000);

    // Reset while waiting for read data
    inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
    arready = 1'b1; rvalid = 1'b0;
    tick();
    tick();
    chk("rst.in_r", {rready, busy}, 2'b11);
    rst_n = 1'b0; inst_req = 1'b0;
    tick();
    chk_all_zero("rst.mid");
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h5555_AAAA;
    tick();
    chk("rst.after1", {inst_done, data_done, rready, busy}, 4'b0000);
    tick();
    chk("rst.after2", {inst_done, data_done, rready, busy}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the core's single AXI3 master port between the instruction-fetch requester and the load/store requester. It sits between the Uranus core's memory ports and the AXI_master register stage. It accepts one outstanding single-beat transaction at a time, grants round-robin with data winning the first tie after reset, and returns read data and completion pulses to the winner.

## Interface
Parameters:
- ID_INST, 4'd0, ARID used for instruction reads
- ID_DATA, 4'd1, ARID/AWID used for data reads/writes

Ports (AXI ports grouped per channel):
- clk  in  1  core clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- inst_req  in  1  fetch request; held with inst_addr until inst_done
- inst_addr  in  32  fetch byte address
- inst_rdata  out  32  fetched word, valid while inst_done=1
- inst_done  out  1  one-cycle completion pulse
- data_req  in  1  load/store request; held with data_* inputs until data_done
- data_wr  in  1  1=store, 0=load
- data_wstrb  in  4  store byte enables
- data_addr  in  32  byte address
- data_wdata  in  32  store data
- data_rdata  out  32  load word, valid while data_done=1
- data_done  out  1  one-cycle completion pulse
- bus_err  out  1  pulses with *_done when RRESP/BRESP != 0
- busy  out  1  1 in any state except IDLE
- AR channel out: arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arvalid 1; in: arready 1
- R channel in: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1; out: rready 1
- AW channel out: awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awvalid 1; in: awready 1
- W channel out: wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1; in: wready 1
- B channel in: bid 4, bresp 2, bvalid 1; out: bready 1

## Operation
- States:
  - IDLE
  - AR: arvalid=1
  - R: rready=1
  - AWW: awvalid/wvalid per pending flags
  - B: bready=1
  - DONE
- Arbitration in IDLE:
  - If exactly one requester is asserting, grant it.
  - If both are asserting, grant the one that is not last_grant.
  - last_grant resets to INST, so data wins the first tie.
  - last_grant updates on every grant.
- On grant, latch the request fields.
  - Address sent is {addr[31:2],2'b00}.
  - Inst requests and data loads go to AR.
  - Data stores go to AWW, with both aw_pend and w_pend set.
- AR -> R on arvalid&arready.
- R -> DONE on rvalid&rlast. rdata and rresp are latched in that cycle.
- AWW:
  - aw_pend clears on awready.
  - w_pend clears on wready.
  - The state moves to B when both flags are clear, counting handshakes in the current cycle.
  - AW and W are independent; either order or the same cycle is legal.
- B -> DONE on bvalid. bresp is latched in that cycle.
- DONE:
  - The winner's *_done is 1.
  - *_rdata carries the latched word; it is 0 for stores.
  - bus_err = (latched resp != 0).
  - DONE always moves to IDLE next.
- Fixed fields: arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01, wlast=1.
- ID fields:
  - arid = ID_INST or ID_DATA according to the winner.
  - awid = wid = ID_DATA.
- rid and bid are ignored, since only one transaction is ever outstanding.
- Requester contract: hold req and its fields stable until done. Req may remain high after done for a new transaction; that transaction is arbitrated in the IDLE cycle that follows DONE.

## Timing
- Reset values:
  - All valid/ready/done/bus_err/busy outputs are 0.
  - All AXI address/data/id/strb outputs are 0.
  - state = IDLE, last_grant = INST, pend flags = 0.
- Reset mid-transaction: the next edge forces IDLE and reset values. The AXI transaction is abandoned; the slave is reset by the same rst_n.
- All outputs are registered; AXI valid rises the cycle after grant.
- Minimum read latency, with arready and rvalid asserted immediately: req seen at edge 0, arvalid at cycle 1, R at cycle 2, done at cycle 3.
- Minimum write latency: done at cycle 3 (IDLE, AWW, B, DONE).
- Valid signals, once asserted, stay high with stable payload until their handshake. They drop on the edge after the handshake.
- busy=1 from the edge after grant through DONE inclusive.

## Structure
- Package mem_arb_pkg holds:
  - state enum: IDLE, AR, R, AWW, B, DONE
  - grant enum: INST, DATA
  - constants AXI_SIZE_WORD=3'b010, AXI_BURST_INCR=2'b01, AXI_LEN_SINGLE=4'd0
- Single module; no sub-module.
- A single always block handles the sequential state; output decode is registered with it.

## Test plan
- Inst read 0xBFC0_0004, arready/rvalid immediate, rdata=0x2408_0001 -> araddr=0xBFC00004, arid=0, inst_done at cycle 3 with inst_rdata=0x24080001.
- Both requesting from reset, data load 0x8000_0010, inst 0xBFC0_0000 held -> data granted first (arid=1). Inst is granted in the IDLE after DONE, and the two then alternate while both stay high.
- Store addr 0x8000_0003, wdata=0xDEADBEEF, wstrb=4'b1000; awready 2 cycles late, wready immediate -> awaddr=0x80000000. wvalid drops after 1 cycle, awvalid is held 3 cycles, data_done after bvalid, data_rdata=0.
- Read with arready delayed 5 cycles and rresp=2'b10 -> arvalid and araddr stable for 6 cycles, inst_done and bus_err pulse together.
- rst_n=0 asserted while in R with rvalid not yet seen -> next edge all outputs 0 and state IDLE, and no done pulse.
